// File: rtl/fifo_pkg.sv
// Shared widths, status type and parameter sanity helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W    = 8;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_AFULL_LVL = 12;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so that count can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  localparam int PTR_W = ptr_w(FIFO_DEPTH);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0};

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: one write port, one registered read port.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // NOTE: storage has no reset; only the control state is cleared, so the array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // NOTE: default assigned first so the held value never infers a latch.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags, sticky errors, invariants.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_afull_chk
    $error("sync_fifo_ctrl: AFULL_LVL must lie in 1..DEPTH");
  end

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_status_t  status_q, status_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  assign wr_acc = wr_en & (~status_q.full | rd_en);
  assign rd_acc = rd_en & ~status_q.empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
    if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // Flags decode the next count so they land in the same cycle as count.
    status_d.full        = (count_d == CW'(DEPTH));
    status_d.empty       = (count_d == '0);
    status_d.almost_full = (count_d >= CW'(AFULL_LVL));

    // Set takes priority over clear.
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
    unf_d = (unf_q & ~clr_err) | (rd_en & status_q.empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      status_q   <= STATUS_RST;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      status_q   <= status_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign rd_valid    = rd_valid_q;
  assign fifo_full   = status_q.full;
  assign fifo_empty  = status_q.empty;
  assign almost_full = status_q.almost_full;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH))
    else $error("sync_fifo_ctrl: count %0d exceeds DEPTH", count);
  a_full_dec: assert property (@(posedge clk) disable iff (!rst_n) fifo_full == (count == CW'(DEPTH)))
    else $error("sync_fifo_ctrl: fifo_full disagrees with count %0d", count);
  a_empty_dec: assert property (@(posedge clk) disable iff (!rst_n) fifo_empty == (count == '0))
    else $error("sync_fifo_ctrl: fifo_empty disagrees with count %0d", count);
  a_not_both: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && fifo_empty))
    else $error("sync_fifo_ctrl: fifo_full and fifo_empty both high");
  a_cnt_inc: assert property (@(posedge clk) disable iff (!rst_n)
                              (wr_acc && !rd_acc) |=> count == $past(count) + CW'(1))
    else $error("sync_fifo_ctrl: count did not increment after a lone write");
  a_cnt_dec: assert property (@(posedge clk) disable iff (!rst_n)
                              (rd_acc && !wr_acc) |=> count == $past(count) - CW'(1))
    else $error("sync_fifo_ctrl: count did not decrement after a lone read");
  a_rd_valid: assert property (@(posedge clk) disable iff (!rst_n) rd_acc |=> rd_valid)
    else $error("sync_fifo_ctrl: rd_valid missing one cycle after an accepted read");
  a_ovf: assert property (@(posedge clk) disable iff (!rst_n)
                          (wr_en && fifo_full && !rd_en) |=> overflow)
    else $error("sync_fifo_ctrl: overflow not set after a write into a full FIFO");

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: queue model plus read-data scoreboard, corner-case vector table, reset checks.
`timescale 1ns/1ps
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, fifo_full, fifo_empty, almost_full, overflow, underflow;
  logic [4:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];   // model contents
  logic [DW-1:0] sb[$];   // expected read data, in order
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_last_rd;

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    logic          ce;
    int            cnt;
    logic          full;
    logic          empty;
    logic          afull;
    logic          ovf;
    logic          unf;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    check({tag, "_full"}, 32'(fifo_full), 32'd0);
    check({tag, "_afull"}, 32'(almost_full), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_last_rd = '0;
  endtask

  // One clock of stimulus; model is advanced from its pre-edge state, then outputs are compared.
  task automatic do_cycle(input logic we, input logic [DW-1:0] wd, input logic re, input logic ce);
    logic m_full, m_empty, wacc, racc;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    wacc    = we && (!m_full || re);
    racc    = re && !m_empty;
    m_ovf   = (m_ovf && !ce) || (we && !wacc);
    m_unf   = (m_unf && !ce) || (re && m_empty);
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(wd);

    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    check("empty", 32'(fifo_empty), 32'(mq.size() == 0));
    check("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc) m_last_rd = sb.pop_front();
    check("rd_data", 32'(rd_data), 32'(m_last_rd));
  endtask

  task automatic run_vec(input int i);
    do_cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ce);
    check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
    check($sformatf("vec%0d_full", i), 32'(fifo_full), 32'(vecs[i].full));
    check($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].empty));
    check($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].afull));
    check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    check($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            we    wd     re    ce    cnt full empty afull ovf  unf
    vecs[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // write while full
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // clear errors
    vecs[2] = '{1'b1, 8'h55, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // both while full
    vecs[3] = '{1'b1, 8'h77, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // both while empty
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // clear errors

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, then drain in order.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, DW'(i), 1'b0, 1'b0);
    check("filled_full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("last_read_data", 32'(rd_data), 32'h0F);
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    check("drained_empty", 32'(fifo_empty), 32'd1);

    // Refill, then full-side corner cases from the table.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_vec(i);
    check("oldest_after_both", 32'(rd_data), 32'h10);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_tail_data", 32'(rd_data), 32'h55);

    // Empty-side corner cases, then retrieve the single accepted word.
    for (int i = 3; i < 5; i++) run_vec(i);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("empty_both_data", 32'(rd_data), 32'h77);

    // Pointer wrap: pointers already sit off zero, so these runs cross the array end.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) do_cycle(1'b1, DW'(8'hA0 + 16 * k + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    check("wrap_count_zero", 32'(count), 32'd0);

    // Asynchronous reset with seven entries held and a read in flight.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("pre_reset_count", 32'(count), 32'd7);
    check("pre_reset_valid", 32'(rd_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_reset("midrst");
    model_reset();
    @(negedge clk);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_hold_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation resumes after reset.
    do_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_reset_data", 32'(rd_data), 32'h3C);
    do_cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
